multicycle_control: RTL and testbench
=====================================

# multicycle_control

Moore-style main control FSM for the multicycle MIPS datapath. It replaces single-cycle opcode decoding with a per-instruction state sequence. It drives the PC, instruction register, memory, ALU-source and register-file enables every cycle, and optionally stalls on a memory ready handshake. It sits between the instruction register's opcode field and the shared-memory multicycle datapath. It adds ori support and flags illegal opcodes.

## Interface
- MEM_HANDSHAKE, 1: 1 = FETCH/MEM_READ/MEM_WRITE hold until mem_ready_i; 0 = every memory access completes in one cycle and mem_ready_i is ignored.
- ALUOP_W, 2: width of ALUOp_o; must be ≥ 2. Codes are zero-extended.
- clk_i  in  1  clock; everything is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- Op_i  in  6  opcode from the instruction register. It is only meaningful outside FETCH.
- mem_ready_i  in  1  memory access completes this cycle.
- PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o  out  1 each.
- ALUSrcB_o  out  2  00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
- PCSource_o  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUOp_o  out  ALUOP_W  00 add, 01 sub, 10 or, 11 R-type (use funct).
- InstrDone_o  out  1  one-cycle pulse in the last cycle of each instruction.
- IllegalOp_o  out  1  one-cycle pulse when an unsupported opcode is decoded.
- state_o  out  4  current state encoding, for debug and the bench.

## Operation
- Supported opcodes: R 000000, addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, j 000010.
- States (4-bit): FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP.
- Outputs not listed for a state are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=1 only in the completing cycle. Go to DECODE on completion.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Latch the I-type ALU code (00 addi, 10 ori) into an internal register.
  - lw/sw → MEM_ADDR; R → EXEC_R; addi/ori → EXEC_I; beq → BRANCH; j → JUMP.
  - Any other opcode: IllegalOp=1, InstrDone=1, → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Go to MEM_WB on completion.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1 → FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. InstrDone=1 and → FETCH on completion.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=11 → R_WB.
- R_WB: RegWrite=1, RegDst=1, InstrDone=1 → FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp = latched code → I_WB.
- I_WB: RegWrite=1, RegDst=0, InstrDone=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, InstrDone=1 → FETCH.
- JUMP: PCWrite=1, PCSource=10, InstrDone=1 → FETCH.
- The "completing cycle" is the cycle with mem_ready_i=1, or every cycle when MEM_HANDSHAKE=0. While not complete, the state holds with the same outputs, and IRWrite, PCWrite and InstrDone stay 0.

## Timing
- Reset:
  - In any cycle with rst_i=1, every output is 0, including state_o (FETCH is encoded as 0).
  - The next state is FETCH, and the latched I-type code clears to 00.
  - The first cycle after reset deasserts is a normal FETCH.
- Reset mid-instruction aborts the instruction with no InstrDone pulse. A mem_ready_i arriving in the same cycle is ignored.
- Zero-wait instruction latency: R/addi/ori/sw 4 cycles, lw 5, beq/j 3, illegal 2.
- Each cycle of mem_ready_i=0 in a memory state adds exactly one cycle.
- mem_ready_i outside FETCH/MEM_READ/MEM_WRITE has no effect.
- Op_i is sampled only in DECODE and MEM_ADDR. The IR is stable in those states.
- IllegalOp_o and InstrDone_o rise together in DECODE for illegal opcodes.

## Structure
- Shared package control_pkg holds: state encodings, opcode constants, ALUOp codes, ALUSrcB/PCSource codes.
- One natural sub-module, opcode_class: a combinational classifier from Op_i to {R, IMM, LOAD, STORE, BRANCH, JUMP, ILLEGAL} plus the I-type ALU code.
- The top level holds the state register, next-state logic and output decode.

## Test plan
- Reset, then R-type with mem_ready_i=1 throughout:
  - state_o steps FETCH, DECODE, EXEC_R, R_WB.
  - ALUOp_o=11 in EXEC_R; RegDst=RegWrite=1 in R_WB.
  - InstrDone pulses in cycle 4.
- lw with MEM_HANDSHAKE=1 and mem_ready_i low for 2 cycles in MEM_READ:
  - 7 cycles total; MemRead=IorD=1 held for 3 cycles.
  - MEM_WB shows MemtoReg=1.
- ori then addi back-to-back: ALUOp_o=10 then 00 in EXEC_I; both have RegDst=0 in I_WB.
- beq and j:
  - 3 cycles each.
  - BRANCH: PCWriteCond=1, PCSource=01, ALUOp=01.
  - JUMP: PCWrite=1, PCSource=10.
- Op_i=111111: IllegalOp=InstrDone=1 in DECODE, then FETCH; no RegWrite or MemWrite at any point.
- rst_i asserted in MEM_WRITE while mem_ready_i=1:
  - MemWrite=0 in that cycle, no InstrDone.
  - FETCH follows.
  - With MEM_HANDSHAKE=0, sw completes in 4 cycles even with mem_ready_i=0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: states, opcodes,
// ALU/mux select codes and the per-cycle control bundle.
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_EXEC_I    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } op_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_OR    = 2'b10;
    localparam logic [1:0] ALU_FUNCT = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier; also yields the ALU code an I-type
// instruction will use in its execute cycle.
module opcode_class
    import control_pkg::*;
(
    input  logic [5:0] op_i,
    output op_class_e  class_o,
    output logic [1:0] imm_alu_o
);

    always_comb begin
        class_o   = CLS_ILLEGAL;
        imm_alu_o = ALU_ADD;
        case (op_i)
            OP_RTYPE: class_o = CLS_R;
            OP_ADDI:  class_o = CLS_IMM;
            OP_ORI: begin
                class_o   = CLS_IMM;
                imm_alu_o = ALU_OR;
            end
            OP_LW:    class_o = CLS_LOAD;
            OP_SW:    class_o = CLS_STORE;
            OP_BEQ:   class_o = CLS_BRANCH;
            OP_J:     class_o = CLS_JUMP;
            default:  class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: one state sequence per
// instruction class, optional stall on a memory ready handshake.
module multicycle_control
    import control_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ALUOP_W       = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         Op_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic               MemtoReg_o,
    output logic               RegWrite_o,
    output logic               RegDst_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [1:0]         PCSource_o,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic               InstrDone_o,
    output logic               IllegalOp_o,
    output logic [3:0]         state_o
);

    localparam bit HANDSHAKE = (MEM_HANDSHAKE != 0);

    state_e     state_q, state_d;
    logic [1:0] imm_alu_q, imm_alu_d;
    op_class_e  op_class;
    logic [1:0] op_imm_alu;
    logic       mem_done;
    ctrl_t      ctrl;

    opcode_class u_opcode_class (
        .op_i      (Op_i),
        .class_o   (op_class),
        .imm_alu_o (op_imm_alu)
    );

    // Without the handshake every memory access is a single-cycle access.
    assign mem_done = !HANDSHAKE || mem_ready_i;

    always_comb begin
        state_d   = state_q;
        imm_alu_d = imm_alu_q;
        case (state_q)
            S_FETCH: begin
                if (mem_done) state_d = S_DECODE;
            end
            S_DECODE: begin
                imm_alu_d = op_imm_alu;
                case (op_class)
                    CLS_LOAD, CLS_STORE: state_d = S_MEM_ADDR;
                    CLS_R:               state_d = S_EXEC_R;
                    CLS_IMM:             state_d = S_EXEC_I;
                    CLS_BRANCH:          state_d = S_BRANCH;
                    CLS_JUMP:            state_d = S_JUMP;
                    default:             state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                state_d = (op_class == CLS_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                if (mem_done) state_d = S_MEM_WB;
            end
            S_MEM_WRITE: begin
                if (mem_done) state_d = S_FETCH;
            end
            S_EXEC_R: state_d = S_R_WB;
            S_EXEC_I: state_d = S_I_WB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            imm_alu_q <= ALU_ADD;
        end else begin
            state_q   <= state_d;
            imm_alu_q <= imm_alu_d;
        end
    end

    // Outputs follow the state; reset forces the whole bundle to zero.
    always_comb begin
        ctrl = '0;
        if (!rst_i) begin
            case (state_q)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.ir_write  = mem_done;
                    ctrl.pc_write  = mem_done;
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH;
                    ctrl.alu_op    = ALU_ADD;
                    if (op_class == CLS_ILLEGAL) begin
                        ctrl.illegal_op = 1'b1;
                        ctrl.instr_done = 1'b1;
                    end
                end
                S_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEM_READ: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_MEM_WRITE: begin
                    ctrl.mem_write  = 1'b1;
                    ctrl.iord       = 1'b1;
                    ctrl.instr_done = mem_done;
                end
                S_EXEC_R: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_EXEC_I: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = imm_alu_q;
                end
                S_I_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_REG;
                    ctrl.alu_op        = ALU_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                    ctrl.instr_done    = 1'b1;
                end
                S_JUMP: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_source  = PCSRC_JUMP;
                    ctrl.instr_done = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign PCWrite_o     = ctrl.pc_write;
    assign PCWriteCond_o = ctrl.pc_write_cond;
    assign IorD_o        = ctrl.iord;
    assign MemRead_o     = ctrl.mem_read;
    assign MemWrite_o    = ctrl.mem_write;
    assign IRWrite_o     = ctrl.ir_write;
    assign MemtoReg_o    = ctrl.mem_to_reg;
    assign RegWrite_o    = ctrl.reg_write;
    assign RegDst_o      = ctrl.reg_dst;
    assign ALUSrcA_o     = ctrl.alu_src_a;
    assign ALUSrcB_o     = ctrl.alu_src_b;
    assign PCSource_o    = ctrl.pc_source;
    assign ALUOp_o       = ALUOP_W'(ctrl.alu_op);
    assign InstrDone_o   = ctrl.instr_done;
    assign IllegalOp_o   = ctrl.illegal_op;
    assign state_o       = rst_i ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected control words and
// per-instruction latencies are queued by the driver and checked by a monitor.
module tb_multicycle_control;
    import control_pkg::*;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

    logic       clk_i = 1'b0;
    logic       rst_i, mem_ready_i;
    logic [5:0] Op_i;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rgw, rgd, srca, done, ill;
    logic [1:0] srcb, pcsrc, aluop;
    logic [3:0] st;

    logic       rst2, rdy2;
    logic [5:0] op2;
    logic       pcw2, pcwc2, iord2, mrd2, mwr2, irw2, m2r2, rgw2, rgd2, srca2, done2, ill2;
    logic [1:0] srcb2, pcsrc2, aluop2;
    logic [3:0] st2;

    logic [21:0] exp_q[$];
    logic [21:0] exp2_q[$];
    int          lat_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        end_req = 1'b0;
    logic        end_ack = 1'b0;

    always #5 clk_i = ~clk_i;

    multicycle_control #(.MEM_HANDSHAKE(1), .ALUOP_W(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .mem_ready_i(mem_ready_i),
        .PCWrite_o(pcw), .PCWriteCond_o(pcwc), .IorD_o(iord), .MemRead_o(mrd),
        .MemWrite_o(mwr), .IRWrite_o(irw), .MemtoReg_o(m2r), .RegWrite_o(rgw),
        .RegDst_o(rgd), .ALUSrcA_o(srca), .ALUSrcB_o(srcb), .PCSource_o(pcsrc),
        .ALUOp_o(aluop), .InstrDone_o(done), .IllegalOp_o(ill), .state_o(st)
    );

    multicycle_control #(.MEM_HANDSHAKE(0), .ALUOP_W(2)) dut_nohs (
        .clk_i(clk_i), .rst_i(rst2), .Op_i(op2), .mem_ready_i(rdy2),
        .PCWrite_o(pcw2), .PCWriteCond_o(pcwc2), .IorD_o(iord2), .MemRead_o(mrd2),
        .MemWrite_o(mwr2), .IRWrite_o(irw2), .MemtoReg_o(m2r2), .RegWrite_o(rgw2),
        .RegDst_o(rgd2), .ALUSrcA_o(srca2), .ALUSrcB_o(srcb2), .PCSource_o(pcsrc2),
        .ALUOp_o(aluop2), .InstrDone_o(done2), .IllegalOp_o(ill2), .state_o(st2)
    );

    // Reference control word for one cycle, straight from the per-state table.
    function automatic logic [21:0] exp_word(input state_e s, input logic cmpl,
                                             input logic [1:0] imm, input logic illg);
        logic e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rgw, e_rgd, e_srca, e_done, e_ill;
        logic [1:0] e_srcb, e_pcsrc, e_aluop;
        {e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rgw, e_rgd, e_srca, e_done, e_ill} = '0;
        {e_srcb, e_pcsrc, e_aluop} = '0;
        case (s)
            S_FETCH:     begin e_mrd = 1; e_srcb = 2'b01; e_irw = cmpl; e_pcw = cmpl; end
            S_DECODE:    begin e_srcb = 2'b11; e_ill = illg; e_done = illg; end
            S_MEM_ADDR:  begin e_srca = 1; e_srcb = 2'b10; end
            S_MEM_READ:  begin e_mrd = 1; e_iord = 1; end
            S_MEM_WB:    begin e_rgw = 1; e_m2r = 1; e_done = 1; end
            S_MEM_WRITE: begin e_mwr = 1; e_iord = 1; e_done = cmpl; end
            S_EXEC_R:    begin e_srca = 1; e_aluop = 2'b11; end
            S_R_WB:      begin e_rgw = 1; e_rgd = 1; e_done = 1; end
            S_EXEC_I:    begin e_srca = 1; e_srcb = 2'b10; e_aluop = imm; end
            S_I_WB:      begin e_rgw = 1; e_done = 1; end
            S_BRANCH:    begin e_srca = 1; e_aluop = 2'b01; e_pcwc = 1; e_pcsrc = 2'b01; e_done = 1; end
            S_JUMP:      begin e_pcw = 1; e_pcsrc = 2'b10; e_done = 1; end
            default:     ;
        endcase
        return {e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rgw, e_rgd, e_srca,
                e_srcb, e_pcsrc, e_aluop, e_done, e_ill, 4'(s)};
    endfunction

    function automatic int kind_of(input logic [5:0] op);
        case (op)
            6'b000000:            return K_R;
            6'b001000, 6'b001101: return K_I;
            6'b100011:            return K_LW;
            6'b101011:            return K_SW;
            6'b000100:            return K_BEQ;
            6'b000010:            return K_J;
            default:              return K_ILL;
        endcase
    endfunction

    function automatic logic is_mem(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

    task automatic drive_cycle(input logic rst, input logic [5:0] op, input logic rdy,
                               input logic [21:0] exp);
        @(posedge clk_i);
        #1;
        rst_i = rst;
        Op_i = op;
        mem_ready_i = rdy;
        exp_q.push_back(exp);
    endtask

    task automatic drive2_cycle(input logic rst, input logic [5:0] op, input logic rdy,
                                input logic [21:0] exp);
        @(posedge clk_i);
        #1;
        rst2 = rst;
        op2 = op;
        rdy2 = rdy;
        exp2_q.push_back(exp);
    endtask

    // One instruction; abort_at >= 0 asserts reset (with mem_ready high) at that step.
    task automatic run_instr(input logic [5:0] op, input int w_fetch, input int w_mem,
                             input int abort_at);
        state_e     steps[$];
        int         k, total;
        logic [1:0] imm;
        k = kind_of(op);
        imm = (op == 6'b001101) ? 2'b10 : 2'b00;
        steps = '{S_FETCH, S_DECODE};
        case (k)
            K_R:   begin steps.push_back(S_EXEC_R); steps.push_back(S_R_WB); end
            K_I:   begin steps.push_back(S_EXEC_I); steps.push_back(S_I_WB); end
            K_LW:  begin steps.push_back(S_MEM_ADDR); steps.push_back(S_MEM_READ); steps.push_back(S_MEM_WB); end
            K_SW:  begin steps.push_back(S_MEM_ADDR); steps.push_back(S_MEM_WRITE); end
            K_BEQ: steps.push_back(S_BRANCH);
            K_J:   steps.push_back(S_JUMP);
            default: ;
        endcase
        total = steps.size() + w_fetch + ((k == K_LW || k == K_SW) ? w_mem : 0);
        if (abort_at < 0) lat_q.push_back(total);
        for (int i = 0; i < steps.size(); i++) begin
            logic [5:0] drv_op;
            drv_op = (steps[i] == S_FETCH) ? 6'($urandom) : op;
            if (i == abort_at) begin
                drive_cycle(1'b1, drv_op, 1'b1, 22'h0);
                return;
            end
            if (is_mem(steps[i])) begin
                for (int w = 0; w < ((steps[i] == S_FETCH) ? w_fetch : w_mem); w++)
                    drive_cycle(1'b0, drv_op, 1'b0, exp_word(steps[i], 1'b0, imm, 1'b0));
                drive_cycle(1'b0, drv_op, 1'b1, exp_word(steps[i], 1'b1, imm, k == K_ILL));
            end else begin
                drive_cycle(1'b0, drv_op, 1'($urandom), exp_word(steps[i], 1'b1, imm, k == K_ILL));
            end
        end
    endtask

    // Monitor: every checked comparison in the bench steps checks/errors here.
    always @(negedge clk_i) begin
        logic [21:0] got, exp;
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            got = {pcw, pcwc, iord, mrd, mwr, irw, m2r, rgw, rgd, srca, srcb, pcsrc, aluop, done, ill, st};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ctrl_word t=%0t got=%h exp=%h", $time, got, exp);
            end
        end
        if (exp2_q.size() != 0) begin
            exp = exp2_q.pop_front();
            got = {pcw2, pcwc2, iord2, mrd2, mwr2, irw2, m2r2, rgw2, rgd2, srca2, srcb2, pcsrc2, aluop2, done2, ill2, st2};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL nohs_word t=%0t got=%h exp=%h", $time, got, exp);
            end
        end
        if (rst_i) begin
            cyc = 0;
        end else begin
            cyc++;
            if (done === 1'b1) begin
                checks++;
                if (lat_q.size() == 0) begin
                    errors++;
                    $display("FAIL latency t=%0t got=%0d exp=none", $time, cyc);
                end else begin
                    int e;
                    e = lat_q.pop_front();
                    if (cyc != e) begin
                        errors++;
                        $display("FAIL latency t=%0t got=%0d exp=%0d", $time, cyc, e);
                    end
                end
                cyc = 0;
            end
        end
        if (end_req && !end_ack) begin
            checks++;
            if (lat_q.size() != 0 || exp_q.size() != 0 || exp2_q.size() != 0) begin
                errors++;
                $display("FAIL drain lat=%0d exp=%0d exp2=%0d", lat_q.size(), exp_q.size(), exp2_q.size());
            end
            end_ack = 1'b1;
        end
    end

    initial begin
        rst_i = 1'b1; Op_i = '0; mem_ready_i = 1'b0;
        rst2 = 1'b1; op2 = '0; rdy2 = 1'b0;
        repeat (3) drive_cycle(1'b1, 6'($urandom), 1'($urandom), 22'h0);

        run_instr(6'b000000, 0, 0, -1);
        run_instr(6'b100011, 0, 2, -1);
        run_instr(6'b001101, 0, 0, -1);
        run_instr(6'b001000, 0, 0, -1);
        run_instr(6'b000100, 0, 0, -1);
        run_instr(6'b000010, 0, 0, -1);
        run_instr(6'b111111, 0, 0, -1);
        run_instr(6'b101011, 1, 0, 3);
        run_instr(6'b101011, 0, 1, -1);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            case ($urandom_range(0, 8))
                0: op = 6'b000000;
                1: op = 6'b001000;
                2: op = 6'b001101;
                3: op = 6'b100011;
                4: op = 6'b101011;
                5: op = 6'b000100;
                6: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0)
                drive_cycle(1'b1, 6'($urandom), 1'($urandom), 22'h0);
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end
        repeat (2) drive_cycle(1'b1, 6'($urandom), 1'($urandom), 22'h0);

        // No-handshake instance: sw finishes in 4 cycles with mem_ready low.
        repeat (2) drive2_cycle(1'b1, 6'b101011, 1'b1, 22'h0);
        drive2_cycle(1'b0, 6'($urandom), 1'b0, exp_word(S_FETCH, 1'b1, 2'b00, 1'b0));
        drive2_cycle(1'b0, 6'b101011, 1'b0, exp_word(S_DECODE, 1'b1, 2'b00, 1'b0));
        drive2_cycle(1'b0, 6'b101011, 1'b0, exp_word(S_MEM_ADDR, 1'b1, 2'b00, 1'b0));
        drive2_cycle(1'b0, 6'b101011, 1'b0, exp_word(S_MEM_WRITE, 1'b1, 2'b00, 1'b0));
        drive2_cycle(1'b0, 6'($urandom), 1'b0, exp_word(S_FETCH, 1'b1, 2'b00, 1'b0));
        drive2_cycle(1'b1, 6'b000000, 1'b0, 22'h0);

        for (int i = 0; i < 100 && (exp_q.size() != 0 || exp2_q.size() != 0); i++)
            @(posedge clk_i);
        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_ack; i++)
            @(posedge clk_i);
        if (!end_ack) $display("FAIL drain_ack got=0 exp=1");
        $display("CHECKS %0d ERRORS %0d", checks, errors + (end_ack ? 0 : 1));
        $finish;
    end

endmodule
